// File: rtl/mem_map_pkg.sv
// Shared memory-map constants, PS/2 set-2 scan codes and the scan FSM state type.
// Pure declarations: no logic, no latency.
// No flow control; imported by the controller and its bench.
package mem_map_pkg;

  // Default MMIO map and the tag byte that marks a valid key read.
  localparam logic [23:0] KEY_ADDR_DEF  = 24'h3B00;
  localparam logic [23:0] STAT_ADDR_DEF = 24'h3B01;
  localparam logic [7:0]  KEY_TAG_DEF   = 8'hFF;

  // Prefix bytes of the PS/2 set-2 protocol.
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Recognised make codes and their ASCII translations.
  localparam logic [7:0] SC_S  = 8'h1B;
  localparam logic [7:0] SC_A  = 8'h1C;
  localparam logic [7:0] SC_W  = 8'h1D;
  localparam logic [7:0] SC_D  = 8'h23;
  localparam logic [7:0] SC_UP = 8'h75;
  localparam logic [7:0] SC_DN = 8'h72;

  localparam logic [7:0] ASC_S  = 8'h53;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_W  = 8'h57;
  localparam logic [7:0] ASC_D  = 8'h44;
  localparam logic [7:0] ASC_UP = 8'h2F;
  localparam logic [7:0] ASC_DN = 8'h5C;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_BRK,
    SCAN_EXT,
    SCAN_EXT_BRK
  } scan_state_e;

  // Returns {hit, ascii}; hit=0 for codes that must be dropped.
  function automatic logic [8:0] scan_xlate(input logic [7:0] code);
    logic [8:0] r;
    r = 9'h000;
    case (code)
      SC_S:    r = {1'b1, ASC_S};
      SC_A:    r = {1'b1, ASC_A};
      SC_W:    r = {1'b1, ASC_W};
      SC_D:    r = {1'b1, ASC_D};
      SC_UP:   r = {1'b1, ASC_UP};
      SC_DN:   r = {1'b1, ASC_DN};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_kbd_fifo_if.sv
// Bundle of the core memory port, the RAM port and the scan-code input.
// Wires only, no latency.
// No backpressure: the core port is a single-cycle strobe bus.
interface mem_ctrl_kbd_fifo_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              core_we;
  logic              core_re;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              scan_valid;
  logic [7:0]        scan_code;

  // Core / environment side.
  modport master (
    output core_we, core_re, core_addr, core_wdata, ram_rdata, scan_valid, scan_code,
    input  core_rdata, ram_we, ram_addr, ram_wdata
  );

  // Memory controller side.
  modport slave (
    input  core_we, core_re, core_addr, core_wdata, ram_rdata, scan_valid, scan_code,
    output core_rdata, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/kbd_fifo.sv
// Circular key FIFO with sticky overflow, flush and overflow-clear.
// Push/pop take effect at the clock edge; head is visible on dout right after.
// Full FIFO drops a push and sets ovf unless a pop frees a slot that same cycle.
module kbd_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int W          = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic                clr_ovf,
  input  logic [W-1:0]        din,
  output logic [W-1:0]        dout,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty,
  output logic                ovf,
  output logic                empty_nxt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [W-1:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  do_push, do_pop, wr_en;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign ovf   = ovf_q;

  // Next-state for pointers, occupancy and overflow; flush overrides everything.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_en    = 1'b0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      wr_en = do_push;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
      if (clr_ovf) ovf_d = 1'b0;
      // A fresh overflow in the clearing cycle is not lost.
      if (push && full && !do_pop) ovf_d = 1'b1;
    end
  end

  assign empty_nxt = (count_d == '0);

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_ctrl_kbd_fifo.sv
// Memory controller: RAM pass-through plus MMIO keyboard FIFO fed by a PS/2 scan FSM.
// Decode and read data are combinational; key pushes are visible one edge after scan_valid.
// No backpressure: a full FIFO drops new keys and flags sticky overflow.
module mem_ctrl_kbd_fifo
  import mem_map_pkg::*;
#(
  parameter int               ADDR_W     = 24,
  parameter int               DATA_W     = 16,
  parameter logic [ADDR_W-1:0] KEY_ADDR  = KEY_ADDR_DEF,
  parameter logic [ADDR_W-1:0] STAT_ADDR = STAT_ADDR_DEF,
  parameter int               DEPTH_LOG2 = 3,
  parameter logic [7:0]       KEY_TAG    = KEY_TAG_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_ctrl_kbd_fifo_if.slave   bus,
  output logic                 key_avail
);
  scan_state_e         state_q, state_d;
  logic                emit;
  logic [7:0]          emit_dat;
  logic [8:0]          xlate;
  logic                is_key, is_stat, is_mmio;
  logic                fifo_pop, fifo_flush, fifo_clr_ovf;
  logic [7:0]          fifo_dout;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                fifo_full, fifo_empty, fifo_ovf, fifo_empty_nxt;
  logic                key_avail_q;

  assign is_key  = (bus.core_addr == KEY_ADDR);
  assign is_stat = (bus.core_addr == STAT_ADDR);
  assign is_mmio = is_key || is_stat;

  assign bus.ram_addr  = bus.core_addr;
  assign bus.ram_wdata = bus.core_wdata;
  assign bus.ram_we    = bus.core_we && !is_mmio;

  assign fifo_pop      = bus.core_re && is_key && !fifo_empty && !bus.core_we;
  assign fifo_flush    = bus.core_we && is_stat && bus.core_wdata[0];
  assign fifo_clr_ovf  = bus.core_we && is_stat && bus.core_wdata[1];

  // Read-data mux: key head, status word or RAM.
  always_comb begin
    bus.core_rdata = bus.ram_rdata;
    if (is_key)
      bus.core_rdata = fifo_empty ? '0 : DATA_W'({KEY_TAG, fifo_dout});
    else if (is_stat)
      bus.core_rdata = DATA_W'({fifo_count, fifo_ovf, fifo_full, fifo_empty});
  end

  assign xlate = scan_xlate(bus.scan_code);

  // Scan FSM next state and emit; only consumes a byte on scan_valid.
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_dat = xlate[7:0];
    if (bus.scan_valid) begin
      case (state_q)
        SCAN_IDLE: begin
          if (bus.scan_code == SC_BREAK)    state_d = SCAN_BRK;
          else if (bus.scan_code == SC_EXT) state_d = SCAN_EXT;
          else                              emit    = xlate[8];
        end
        SCAN_EXT: begin
          if (bus.scan_code == SC_BREAK) begin
            state_d = SCAN_EXT_BRK;
          end else begin
            // Only the two arrow codes are meaningful after E0.
            emit    = (bus.scan_code == SC_UP) || (bus.scan_code == SC_DN);
            state_d = SCAN_IDLE;
          end
        end
        default: state_d = SCAN_IDLE;  // break codes: swallow the released key
      endcase
    end
  end

  // FSM state register and key_avail flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN_IDLE;
      key_avail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_avail_q <= !fifo_empty_nxt;
    end
  end

  assign key_avail = key_avail_q;

  kbd_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .W          (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (emit),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .clr_ovf   (fifo_clr_ovf),
    .din       (emit_dat),
    .dout      (fifo_dout),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ovf       (fifo_ovf),
    .empty_nxt (fifo_empty_nxt)
  );

endmodule

// File: tb/tb_mem_ctrl_kbd_fifo.sv
// Bench for mem_ctrl_kbd_fifo: combinational decode vectors plus key FIFO sequences.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Status word layout: {count[3:0], ovf, full, empty}.
module tb_mem_ctrl_kbd_fifo;
  import mem_map_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic key_avail;
  int   n_total = 0;
  int   n_bad   = 0;

  localparam logic [23:0] IDLE_ADDR = 24'h000200;

  mem_ctrl_kbd_fifo_if #(.ADDR_W(24), .DATA_W(16)) bus ();

  mem_ctrl_kbd_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .key_avail (key_avail)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] ram_rd;
    logic        exp_ram_we;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.core_we    = 1'b0;
    bus.core_re    = 1'b0;
    bus.core_addr  = IDLE_ADDR;
    bus.core_wdata = 16'h0000;
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
  endtask

  task automatic scan(input logic [7:0] code);
    bus.scan_valid = 1'b1;
    bus.scan_code  = code;
    @(posedge clk); #1;
    bus.scan_valid = 1'b0;
  endtask

  task automatic read_key(output logic [15:0] v);
    bus.core_addr = KEY_ADDR_DEF;
    bus.core_re   = 1'b1;
    #1 v = bus.core_rdata;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic read_stat(output logic [15:0] v);
    bus.core_addr = STAT_ADDR_DEF;
    #1 v = bus.core_rdata;
    idle();
  endtask

  task automatic write_stat(input logic [15:0] d);
    bus.core_we    = 1'b1;
    bus.core_addr  = STAT_ADDR_DEF;
    bus.core_wdata = d;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    logic [15:0] v;

    //            name            we    re    addr           wdata     ram_rd    ram_we exp_rdata
    vecs[0] = '{"pt_write",     1'b1, 1'b0, 24'h000100,    16'hBEEF, 16'h0000, 1'b1, 16'h0000};
    vecs[1] = '{"pt_read",      1'b0, 1'b1, 24'h000100,    16'h0000, 16'h1234, 1'b0, 16'h1234};
    vecs[2] = '{"key_empty",    1'b0, 1'b1, KEY_ADDR_DEF,  16'h0000, 16'hAAAA, 1'b0, 16'h0000};
    vecs[3] = '{"stat_empty",   1'b0, 1'b1, STAT_ADDR_DEF, 16'h0000, 16'hAAAA, 1'b0, 16'h0001};
    vecs[4] = '{"key_wr_prot",  1'b1, 1'b0, KEY_ADDR_DEF,  16'h5555, 16'h0000, 1'b0, 16'h0000};
    vecs[5] = '{"stat_wr_prot", 1'b1, 1'b0, STAT_ADDR_DEF, 16'h0000, 16'h0000, 1'b0, 16'h0001};
    vecs[6] = '{"near_mmio",    1'b1, 1'b0, 24'h003B02,    16'h0F0F, 16'h7777, 1'b1, 16'h7777};
    vecs[7] = '{"below_mmio",   1'b0, 1'b1, 24'h003AFF,    16'h0000, 16'hC3C3, 1'b0, 16'hC3C3};

    idle();
    bus.ram_rdata = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state.
    check("rst_key_avail", 16'(key_avail), 16'h0000);
    read_stat(v); check("rst_status", v, 16'h0001);

    // Combinational decode vectors on an empty FIFO.
    for (int i = 0; i < 8; i++) begin
      bus.core_we    = vecs[i].we;
      bus.core_re    = vecs[i].re;
      bus.core_addr  = vecs[i].addr;
      bus.core_wdata = vecs[i].wdata;
      bus.ram_rdata  = vecs[i].ram_rd;
      #1;
      check({vecs[i].name, "_ram_we"}, 16'(bus.ram_we), 16'(vecs[i].exp_ram_we));
      check({vecs[i].name, "_rdata"}, bus.core_rdata, vecs[i].exp_rdata);
      check({vecs[i].name, "_ram_addr"}, bus.ram_addr[15:0], vecs[i].addr[15:0]);
      check({vecs[i].name, "_ram_wdata"}, bus.ram_wdata, vecs[i].wdata);
      @(posedge clk); #1;
      idle();
    end

    // Make/break with push visibility: old value during scan_valid, new right after.
    bus.core_addr  = KEY_ADDR_DEF;
    bus.scan_valid = 1'b1;
    bus.scan_code  = SC_A;
    #1 check("vis_before", bus.core_rdata, 16'h0000);
    @(posedge clk); #1;
    check("vis_after", bus.core_rdata, 16'hFF41);
    idle();
    scan(SC_BREAK); scan(SC_A);
    read_stat(v); check("mb_status", v, 16'h0008);
    check("mb_avail1", 16'(key_avail), 16'h0001);
    read_key(v); check("mb_read", v, 16'hFF41);
    check("mb_avail0", 16'(key_avail), 16'h0000);
    read_key(v); check("mb_read_empty", v, 16'h0000);

    // Extended prefix, extended break, plain make and an unmapped code.
    scan(SC_EXT); scan(SC_UP);
    scan(SC_EXT); scan(SC_BREAK); scan(SC_UP);
    scan(SC_S);
    scan(8'h5A);
    read_stat(v); check("ext_status", v, 16'h0010);
    read_key(v); check("ext_read0", v, 16'hFF2F);
    read_key(v); check("ext_read1", v, 16'hFF53);
    read_key(v); check("ext_read2", v, 16'h0000);
    scan(SC_DN);
    read_key(v); check("dn_unprefixed", v, 16'hFF5C);

    // Overflow: nine makes into eight slots.
    repeat (9) scan(SC_W);
    read_stat(v); check("ovf_status", v, 16'h0046);
    write_stat(16'h0002);
    read_stat(v); check("ovf_cleared", v, 16'h0042);

    // Push and pop in the same cycle while full.
    bus.core_addr  = KEY_ADDR_DEF;
    bus.core_re    = 1'b1;
    bus.scan_valid = 1'b1;
    bus.scan_code  = SC_D;
    #1 check("sim_head", bus.core_rdata, 16'hFF57);
    @(posedge clk); #1;
    idle();
    read_stat(v); check("sim_status", v, 16'h0042);
    for (int i = 0; i < 7; i++) begin
      read_key(v); check("sim_drain", v, 16'hFF57);
    end
    read_key(v); check("sim_last", v, 16'hFF44);
    read_stat(v); check("sim_empty", v, 16'h0001);

    // Flush beats a concurrent push.
    scan(SC_A);
    bus.core_we    = 1'b1;
    bus.core_addr  = STAT_ADDR_DEF;
    bus.core_wdata = 16'h0001;
    bus.scan_valid = 1'b1;
    bus.scan_code  = SC_W;
    @(posedge clk); #1;
    idle();
    read_stat(v); check("flush_status", v, 16'h0001);
    check("flush_avail", 16'(key_avail), 16'h0000);

    // Flush also clears a pending overflow.
    repeat (9) scan(SC_S);
    write_stat(16'h0001);
    read_stat(v); check("flush_ovf", v, 16'h0001);

    // Reset mid-sequence discards the break prefix; RAM path stays live.
    scan(SC_W);
    scan(SC_BREAK);
    rst_n = 1'b0;
    bus.core_we    = 1'b1;
    bus.core_addr  = 24'h000100;
    bus.core_wdata = 16'hBEEF;
    #1 check("rst_ram_live", 16'(bus.ram_we), 16'h0001);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    @(posedge clk); #1;
    read_stat(v); check("rst_mid_status", v, 16'h0001);
    check("rst_mid_avail", 16'(key_avail), 16'h0000);
    scan(SC_A);
    read_key(v); check("rst_prefix_gone", v, 16'hFF41);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
